// File: rtl/sccb_slave_if.sv
// Register-file side of the SCCB target: pointer, write data/strobe and read
// strobe/data. The target drives requests (master); the register file answers.
interface sccb_slave_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  modport master (
    output reg_addr, reg_wdata, reg_we, reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_we, reg_re,
    output reg_rdata
  );
endinterface

// File: rtl/sccb_slave.sv
// Bit-level SCCB/I2C target with sub-address and auto-incrementing register
// pointer. SDA is open-drain: only ever driven low or released.
module sccb_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h21
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl,
  inout  wire         sda,
  sccb_slave_if.master rf,
  output logic        busy,
  output logic [3:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_WAIT_STOP
  } state_t;

  // Handshake: reg_we/reg_re are single-cycle strobes qualified by reg_addr in
  // the same cycle; reg_rdata is expected valid the cycle after reg_re.
  state_t     state_q, state_d;
  logic [2:0] scl_sync_q, scl_sync_d;
  logic [2:0] sda_sync_q, sda_sync_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       sda_low_q, sda_low_d;
  logic       first_q, first_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic       rd_cap_q, rd_cap_d;
  logic       inc_q, inc_d;

  logic scl_s, sda_s, scl_rise, scl_fall, sda_rise, sda_fall, scl_hi;
  logic start_ev, stop_ev;

  // Stage [1] is the synchronized level, stage [2] its previous value.
  assign scl_s    = scl_sync_q[1];
  assign sda_s    = sda_sync_q[1];
  assign scl_rise = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall = ~scl_sync_q[1] & scl_sync_q[2];
  assign sda_rise = sda_sync_q[1] & ~sda_sync_q[2];
  assign sda_fall = ~sda_sync_q[1] & sda_sync_q[2];
  assign scl_hi   = scl_sync_q[1] & scl_sync_q[2];
  assign start_ev = scl_hi & sda_fall;
  assign stop_ev  = scl_hi & sda_rise;

  always_comb begin
    state_d    = state_q;
    scl_sync_d = {scl_sync_q[1:0], scl};
    sda_sync_d = {sda_sync_q[1:0], sda};
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    sda_low_d  = sda_low_q;
    first_d    = first_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    rd_cap_d   = re_q;
    inc_d      = 1'b0;

    if (rd_cap_q) tx_d = rf.reg_rdata;
    if (inc_q)    addr_d = addr_q + 8'd1;

    if (start_ev) begin
      state_d   = S_ADDR;
      bit_cnt_d = 4'd0;
      sda_low_d = 1'b0;
    end else if (stop_ev) begin
      state_d   = S_IDLE;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            rx_d      = {rx_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (rx_q[7:1] == DEV_ADDR) begin
              sda_low_d = 1'b1;
              busy_d    = 1'b1;
              rw_d      = rx_q[0];
              re_d      = rx_q[0];
              state_d   = S_ADDR_ACK;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              sda_low_d = ~tx_q[7];
              tx_d      = {tx_q[6:0], 1'b0};
              state_d   = S_RD_BYTE;
            end else begin
              sda_low_d = 1'b0;
              first_d   = 1'b1;
              state_d   = S_WR_BYTE;
            end
          end
        end
        S_WR_BYTE: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            rx_d      = {rx_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_low_d = 1'b1;
            state_d   = S_WR_ACK;
            if (first_q) begin
              addr_d  = rx_q;
              first_d = 1'b0;
            end else begin
              wdata_d = rx_q;
              we_d    = 1'b1;
              inc_d   = 1'b1;
            end
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            sda_low_d = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = S_WR_BYTE;
          end
        end
        S_RD_BYTE: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_low_d = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = S_RD_ACK;
            end else begin
              sda_low_d = ~tx_q[7];
              tx_d      = {tx_q[6:0], 1'b0};
            end
          end
        end
        S_RD_ACK: begin
          // Master ACK asks for the next register; NACK ends the read.
          if (scl_rise) begin
            if (!sda_s) begin
              addr_d    = addr_q + 8'd1;
              re_d      = 1'b1;
              bit_cnt_d = 4'd0;
              state_d   = S_RD_BYTE;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      bit_cnt_q  <= 4'd0;
      rx_q       <= 8'd0;
      tx_q       <= 8'd0;
      sda_low_q  <= 1'b0;
      first_q    <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      addr_q     <= 8'd0;
      wdata_q    <= 8'd0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      rd_cap_q   <= 1'b0;
      inc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      sda_low_q  <= sda_low_d;
      first_q    <= first_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      rd_cap_q   <= rd_cap_d;
      inc_q      <= inc_d;
    end
  end

  assign sda          = sda_low_q ? 1'b0 : 1'bz;
  assign rf.reg_addr  = addr_q;
  assign rf.reg_wdata = wdata_q;
  assign rf.reg_we    = we_q;
  assign rf.reg_re    = re_q;
  assign busy         = busy_q;
  assign state        = {1'b0, state_q};

endmodule

// File: tb/tb_sccb_slave.sv
// Directed bench for sccb_slave: bit-banged bus master, small register-file
// model, write scoreboard, final summary.
module tb_sccb_slave;
  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  wire  sda;
  logic [3:0] state;
  logic busy;

  sccb_slave_if rif();

  assign sda = sda_m ? 1'bz : 1'b0;
  pullup (sda);

  sccb_slave dut (
    .clk   (clk),
    .rst_n (rst_n),
    .scl   (scl),
    .sda   (sda),
    .rf    (rif.master),
    .busy  (busy),
    .state (state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  logic prev_we = 1'b0;
  logic [15:0] exp_q[$];
  logic [7:0] mem [256];
  logic [7:0] rdata_r = 8'h00;

  assign rif.reg_rdata = rdata_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic sda_bit();
    return (sda === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  // Register-file read port: data is valid the cycle after reg_re.
  always @(posedge clk) if (rif.reg_re) rdata_r <= mem[rif.reg_addr];

  // Write scoreboard and strobe counters.
  always @(negedge clk) begin
    if (rif.reg_re) re_cnt++;
    if (rif.reg_we) begin
      we_cnt++;
      check("we_width", {31'd0, prev_we}, 32'd0);
      if (exp_q.size() == 0) check("unexpected_we", {16'd0, rif.reg_addr, rif.reg_wdata}, 32'hFFFF);
      else check("we_addr_data", {16'd0, rif.reg_addr, rif.reg_wdata}, {16'd0, exp_q.pop_front()});
    end
    prev_we = rif.reg_we;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl = 1'b0;   wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;  wait_clk(Q);
    scl = 1'b1; wait_clk(2*Q);
    scl = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sda_m = 1'b1; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    ack = ~sda_bit();
    wait_clk(Q);
    scl = 1'b0;   wait_clk(Q);
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d);
    sda_m = 1'b1;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      wait_clk(Q);
      scl = 1'b1; wait_clk(Q);
      d = {d[6:0], sda_bit()};
      wait_clk(Q);
      scl = 1'b0; wait_clk(Q);
    end
    sda_m = ~m_ack; wait_clk(Q);
    scl = 1'b1;     wait_clk(2*Q);
    scl = 1'b0;
    sda_m = 1'b1;   wait_clk(Q);
  endtask

  logic ack;
  logic [7:0] d;
  int we0, re0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
    mem[8'h0A] = 8'h7F;
    mem[8'h20] = 8'h11;
    mem[8'h21] = 8'h22;
    mem[8'h22] = 8'h33;

    // Reset state
    wait_clk(3);
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_addr", {24'd0, rif.reg_addr}, 32'd0);
    check("rst_wdata", {24'd0, rif.reg_wdata}, 32'd0);
    check("rst_strobes", {30'd0, rif.reg_we, rif.reg_re}, 32'd0);
    check("rst_sda", {31'd0, sda_bit()}, 32'd1);
    rst_n = 1'b1;
    wait_clk(4);

    // Single register write
    exp_q.push_back({8'h12, 8'h80});
    bus_start();
    write_byte(8'h42, ack); check("wr_ack_dev", {31'd0, ack}, 32'd1);
    check("wr_busy", {31'd0, busy}, 32'd1);
    write_byte(8'h12, ack); check("wr_ack_sub", {31'd0, ack}, 32'd1);
    write_byte(8'h80, ack); check("wr_ack_data", {31'd0, ack}, 32'd1);
    bus_stop();
    check("wr_count", we_cnt, 32'd1);
    check("wr_addr_after", {24'd0, rif.reg_addr}, 32'h13);
    check("wr_busy_after", {31'd0, busy}, 32'd0);
    check("wr_state_after", {28'd0, state}, 32'd0);

    // Burst write wrapping 0xFF -> 0x00
    exp_q.push_back({8'hFE, 8'hA1});
    exp_q.push_back({8'hFF, 8'hB2});
    exp_q.push_back({8'h00, 8'hC3});
    we0 = we_cnt;
    bus_start();
    write_byte(8'h42, ack);
    write_byte(8'hFE, ack);
    write_byte(8'hA1, ack);
    write_byte(8'hB2, ack);
    write_byte(8'hC3, ack); check("burst_ack_last", {31'd0, ack}, 32'd1);
    bus_stop();
    check("burst_count", we_cnt - we0, 32'd3);
    check("burst_addr_after", {24'd0, rif.reg_addr}, 32'h01);
    check("burst_q_empty", exp_q.size(), 32'd0);

    // SCCB read: set pointer, stop, then single-byte read with NACK
    re0 = re_cnt;
    bus_start();
    write_byte(8'h42, ack);
    write_byte(8'h0A, ack);
    bus_stop();
    bus_start();
    write_byte(8'h43, ack); check("rd_ack_dev", {31'd0, ack}, 32'd1);
    read_byte(1'b0, d);
    check("rd_data", {24'd0, d}, 32'h7F);
    check("rd_wait_stop", {28'd0, state}, 32'd7);
    bus_stop();
    check("rd_idle", {28'd0, state}, 32'd0);
    check("rd_re_count", re_cnt - re0, 32'd1);

    // Repeated-START burst read of three registers
    re0 = re_cnt;
    bus_start();
    write_byte(8'h42, ack);
    write_byte(8'h20, ack);
    bus_start();
    write_byte(8'h43, ack); check("rs_ack_dev", {31'd0, ack}, 32'd1);
    read_byte(1'b1, d); check("rs_data0", {24'd0, d}, 32'h11);
    read_byte(1'b1, d); check("rs_data1", {24'd0, d}, 32'h22);
    read_byte(1'b0, d); check("rs_data2", {24'd0, d}, 32'h33);
    bus_stop();
    check("rs_re_count", re_cnt - re0, 32'd3);
    check("rs_addr_after", {24'd0, rif.reg_addr}, 32'h22);

    // Address mismatch
    we0 = we_cnt; re0 = re_cnt;
    bus_start();
    write_byte(8'h60, ack);
    check("nm_ack", {31'd0, ack}, 32'd0);
    check("nm_busy", {31'd0, busy}, 32'd0);
    check("nm_state", {28'd0, state}, 32'd7);
    bus_stop();
    check("nm_strobes", (we_cnt - we0) + (re_cnt - re0), 32'd0);

    // Abort: STOP after four data bits
    we0 = we_cnt;
    bus_start();
    write_byte(8'h42, ack);
    write_byte(8'h33, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    bus_stop();
    check("ab_we", we_cnt - we0, 32'd0);
    check("ab_state", {28'd0, state}, 32'd0);
    check("ab_sda", {31'd0, sda_bit()}, 32'd1);
    check("ab_busy", {31'd0, busy}, 32'd0);

    // Abort: reset asserted while the target drives ACK
    we0 = we_cnt;
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(8'h42 >> i);
    sda_m = 1'b1;
    wait_clk(2);
    check("rs_ack_drive", {31'd0, sda_bit()}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_sda_release", {31'd0, sda_bit()}, 32'd1);
    check("rst_mid_state", {28'd0, state}, 32'd0);
    wait_clk(2);
    scl = 1'b1;
    wait_clk(Q);
    rst_n = 1'b1;
    wait_clk(Q);
    check("rst_mid_we", we_cnt - we0, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
